// File: rtl/ex_operand_bypass.sv
// ID/EX, EX/MEM and MEM/WB pipeline registers with EX-stage operand forwarding
// and load-use stall bookkeeping (saturating stall count, sticky over-long-stall flag).
module ex_operand_bypass #(
    parameter int XLEN      = 32,
    parameter int STALL_MAX = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fwd_ex_ex1,
    input  logic            fwd_ex_ex2,
    input  logic            fwd_mem_ex1,
    input  logic            fwd_mem_ex2,
    input  logic            id_valid,
    input  logic            id_wen,
    input  logic            id_is_load,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic            ex_valid,
    output logic            ex_wen,
    output logic            ex_is_load,
    output logic [4:0]      ex_rd,
    output logic            if_hold,
    output logic            wb_wen,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [15:0]     stall_cnt,
    output logic            stall_err
);

    localparam logic [15:0] STALL_LIMIT = 16'(STALL_MAX);

    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic            ex_fwd_ex1;
    logic            ex_fwd_ex2;
    logic            ex_fwd_mem1;
    logic            ex_fwd_mem2;

    logic            mem_valid;
    logic            mem_wen;
    logic            mem_is_load;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_alu;

    logic            wb_valid;
    logic            wb_wen_q;

    logic [15:0]     stall_run;

    // A stall replaces the ID instruction with a bubble; its forwarding flags are dropped.
    always_ff @(posedge clk) begin
        if (!rst || stall) begin
            ex_valid    <= 1'b0;
            ex_wen      <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_rd       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_fwd_ex1  <= 1'b0;
            ex_fwd_ex2  <= 1'b0;
            ex_fwd_mem1 <= 1'b0;
            ex_fwd_mem2 <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_wen      <= id_wen;
            ex_is_load  <= id_is_load;
            ex_rd       <= id_rd;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_fwd_ex1  <= fwd_ex_ex1;
            ex_fwd_ex2  <= fwd_ex_ex2;
            ex_fwd_mem1 <= fwd_mem_ex1;
            ex_fwd_mem2 <= fwd_mem_ex2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_valid   <= 1'b0;
            mem_wen     <= 1'b0;
            mem_is_load <= 1'b0;
            mem_rd      <= '0;
            mem_alu     <= '0;
            wb_valid    <= 1'b0;
            wb_wen_q    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else begin
            mem_valid   <= ex_valid;
            mem_wen     <= ex_wen;
            mem_is_load <= ex_is_load;
            mem_rd      <= ex_rd;
            mem_alu     <= alu_result;
            wb_valid    <= mem_valid;
            wb_wen_q    <= mem_wen;
            wb_rd       <= mem_rd;
            wb_data     <= mem_is_load ? mem_rdata : mem_alu;
        end
    end

    // Flags are trusted as-is: the hazard detector decides, even if the source slot is empty.
    always_comb begin
        ex_op1 = ex_fwd_ex1 ? mem_alu : (ex_fwd_mem1 ? wb_data : ex_rs1_data);
        ex_op2 = ex_fwd_ex2 ? mem_alu : (ex_fwd_mem2 ? wb_data : ex_rs2_data);
    end

    assign wb_wen  = wb_valid && wb_wen_q && (wb_rd != 5'd0);
    assign if_hold = stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            stall_run <= '0;
            stall_err <= 1'b0;
        end else if (stall) begin
            if (stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (stall_run != 16'hFFFF) begin
                stall_run <= stall_run + 16'd1;
            end
            if (stall_run >= STALL_LIMIT) begin
                stall_err <= 1'b1;
            end
        end else begin
            stall_run <= '0;
        end
    end

endmodule

// File: tb/tb_ex_operand_bypass.sv
// Scoreboard bench for ex_operand_bypass: directed instruction stream with
// hand-computed operands/writebacks, plus direct checks of stall bookkeeping.
module tb_ex_operand_bypass;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            fwd_ex_ex1;
    logic            fwd_ex_ex2;
    logic            fwd_mem_ex1;
    logic            fwd_mem_ex2;
    logic            id_valid;
    logic            id_wen;
    logic            id_is_load;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] ex_op1;
    logic [XLEN-1:0] ex_op2;
    logic            ex_valid;
    logic            ex_wen;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic            if_hold;
    logic            wb_wen;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [15:0]     stall_cnt;
    logic            stall_err;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } ex_exp_t;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_exp_t;

    ex_exp_t ex_q[$];
    wb_exp_t wb_q[$];

    int total = 0;
    int bad   = 0;

    ex_operand_bypass #(.XLEN(XLEN), .STALL_MAX(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .fwd_ex_ex1  (fwd_ex_ex1),
        .fwd_ex_ex2  (fwd_ex_ex2),
        .fwd_mem_ex1 (fwd_mem_ex1),
        .fwd_mem_ex2 (fwd_mem_ex2),
        .id_valid    (id_valid),
        .id_wen      (id_wen),
        .id_is_load  (id_is_load),
        .id_rd       (id_rd),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .alu_result  (alu_result),
        .mem_rdata   (mem_rdata),
        .ex_op1      (ex_op1),
        .ex_op2      (ex_op2),
        .ex_valid    (ex_valid),
        .ex_wen      (ex_wen),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .if_hold     (if_hold),
        .wb_wen      (wb_wen),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .stall_cnt   (stall_cnt),
        .stall_err   (stall_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // flags = {fwd_ex_ex1, fwd_ex_ex2, fwd_mem_ex1, fwd_mem_ex2}
    task automatic applyStimulus(input logic v, input logic w, input logic ld,
                                 input logic [4:0] rd, input logic [XLEN-1:0] r1,
                                 input logic [XLEN-1:0] r2, input logic [3:0] flags,
                                 input logic st, input logic [XLEN-1:0] alu,
                                 input logic [XLEN-1:0] mrd);
        id_valid    = v;
        id_wen      = w;
        id_is_load  = ld;
        id_rd       = rd;
        id_rs1_data = r1;
        id_rs2_data = r2;
        fwd_ex_ex1  = flags[3];
        fwd_ex_ex2  = flags[2];
        fwd_mem_ex1 = flags[1];
        fwd_mem_ex2 = flags[0];
        stall       = st;
        alu_result  = alu;
        mem_rdata   = mrd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st, input logic [XLEN-1:0] alu);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 4'b0000, st, alu, '0);
    endtask

    task automatic expectEx(input logic [4:0] rd, input logic [XLEN-1:0] op1,
                            input logic [XLEN-1:0] op2);
        ex_exp_t e;
        e.rd  = rd;
        e.op1 = op1;
        e.op2 = op2;
        ex_q.push_back(e);
    endtask

    task automatic expectWb(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wb_exp_t e;
        e.rd   = rd;
        e.data = data;
        wb_q.push_back(e);
    endtask

    // Monitor: every valid instruction in EX and every register-file write is matched in order.
    always @(negedge clk) begin
        if (ex_valid === 1'b1) begin
            if (ex_q.size() == 0) begin
                checkOutput("ex_unexpected_rd", {27'd0, ex_rd}, 32'hFFFF_FFFF);
            end else begin
                ex_exp_t e;
                e = ex_q.pop_front();
                checkOutput("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                checkOutput("ex_op1", ex_op1, e.op1);
                checkOutput("ex_op2", ex_op2, e.op2);
            end
        end
        if (wb_wen === 1'b1) begin
            if (wb_q.size() == 0) begin
                checkOutput("wb_unexpected_rd", {27'd0, wb_rd}, 32'hFFFF_FFFF);
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                checkOutput("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 32'h5, 32'h7, 4'b1111, 1'b0, 32'h1, 32'h2);
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 32'h5, 32'h7, 4'b1111, 1'b1, 32'h1, 32'h2);
        checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        checkOutput("rst_ex_op1", ex_op1, 32'd0);
        checkOutput("rst_ex_op2", ex_op2, 32'd0);
        checkOutput("rst_wb_wen", {31'd0, wb_wen}, 32'd0);
        checkOutput("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        checkOutput("rst_stall_err", {31'd0, stall_err}, 32'd0);

        rst = 1'b1;
        // c0: I1 plain operands
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'h5, 32'h7, 4'b0000, 1'b0, 32'h0, 32'h0);
        expectEx(5'd1, 32'h5, 32'h7);
        expectWb(5'd1, 32'h10);
        // c1: I2 forwards rs1 from I1 (EX->EX)
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 32'h3, 32'h9, 4'b1000, 1'b0, 32'h10, 32'h0);
        expectEx(5'd2, 32'h10, 32'h9);
        expectWb(5'd2, 32'h20);
        // c2: I3 both flags on rs1 (EX wins), rs2 from MEM
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 32'h55, 32'h66, 4'b1011, 1'b0, 32'h20, 32'h0);
        expectEx(5'd3, 32'h20, 32'h10);
        expectWb(5'd3, 32'h30);
        // c3: I4 load; I2 in MEM is not a load so mem_rdata must be ignored
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd4, 32'h1, 32'h2, 4'b0000, 1'b0, 32'h30, 32'hEE);
        expectEx(5'd4, 32'h1, 32'h2);
        expectWb(5'd4, 32'hAB);
        // c4: load-use stall; I5 with a flag set must become a bubble
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 32'h11, 32'h22, 4'b0100, 1'b1, 32'h44, 32'h0);
        checkOutput("stall_if_hold", {31'd0, if_hold}, 32'd1);
        checkOutput("bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("bubble_ex_rd", {27'd0, ex_rd}, 32'd0);
        checkOutput("bubble_ex_op2", ex_op2, 32'd0);
        checkOutput("stall1_cnt", {16'd0, stall_cnt}, 32'd1);
        checkOutput("stall1_err", {31'd0, stall_err}, 32'd0);
        // c5: I5 reissued, rs2 from loaded value
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 32'h11, 32'h22, 4'b0001, 1'b0, 32'h0, 32'hAB);
        checkOutput("nostall_if_hold", {31'd0, if_hold}, 32'd0);
        expectEx(5'd5, 32'h11, 32'hAB);
        expectWb(5'd5, 32'h2);
        // c6: I6 writes x0
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'h1, 32'h2, 4'b0000, 1'b0, 32'h2, 32'h0);
        expectEx(5'd0, 32'h1, 32'h2);
        // c7: I7 both rs1 flags: EX/MEM=0x1, wb_data=0x2
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 32'h78, 4'b1010, 1'b0, 32'h1, 32'h0);
        expectEx(5'd7, 32'h1, 32'h78);
        expectWb(5'd7, 32'h70);
        // c8: empty slot; I6 (rd=0) now in WB
        idle(1'b0, 32'h70);
        checkOutput("rd0_wb_wen", {31'd0, wb_wen}, 32'd0);
        // c9: I9 forwards from the empty slot ahead of it
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 32'h91, 32'h92, 4'b1000, 1'b0, 32'h99, 32'h0);
        expectEx(5'd9, 32'h99, 32'h92);
        expectWb(5'd9, 32'h9A);
        idle(1'b0, 32'h9A);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);

        // Over-long stall sets the sticky error
        idle(1'b1, 32'h0);
        checkOutput("run1_cnt", {16'd0, stall_cnt}, 32'd2);
        checkOutput("run1_err", {31'd0, stall_err}, 32'd0);
        idle(1'b1, 32'h0);
        checkOutput("run2_cnt", {16'd0, stall_cnt}, 32'd3);
        checkOutput("run2_err", {31'd0, stall_err}, 32'd1);
        idle(1'b0, 32'h0);
        checkOutput("sticky_err", {31'd0, stall_err}, 32'd1);
        checkOutput("sticky_cnt", {16'd0, stall_cnt}, 32'd3);

        // Reset in the middle of a stall run restarts the run from zero
        idle(1'b1, 32'h0);
        rst = 1'b0;
        idle(1'b1, 32'h0);
        checkOutput("rst2_err", {31'd0, stall_err}, 32'd0);
        checkOutput("rst2_cnt", {16'd0, stall_cnt}, 32'd0);
        checkOutput("rst2_wb_wen", {31'd0, wb_wen}, 32'd0);
        rst = 1'b1;
        idle(1'b1, 32'h0);
        checkOutput("post_rst_run_err", {31'd0, stall_err}, 32'd0);
        checkOutput("post_rst_cnt", {16'd0, stall_cnt}, 32'd1);
        idle(1'b1, 32'h0);
        checkOutput("post_rst_run2_err", {31'd0, stall_err}, 32'd1);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);

        checkOutput("ex_queue_drained", 32'(ex_q.size()), 32'd0);
        checkOutput("wb_queue_drained", 32'(wb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_operand_bypass.md
EX_OPERAND_BYPASS -- requirements
Module: ex_operand_bypass

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter STALL_MAX, default 1: longest legal run of consecutive stall cycles.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 stall  in  1  load-use stall request from the hazard detector.
REQ-006 fwd_ex_ex1, fwd_ex_ex2  in  1 each  rs1/rs2 take the result of the instruction one ahead.
REQ-007 fwd_mem_ex1, fwd_mem_ex2  in  1 each  rs1/rs2 take the result of the instruction two ahead.
REQ-008 id_valid, id_wen, id_is_load  in  1 each  ID-stage instruction valid, writes rd, is a load.
REQ-009 id_rd  in  5  ID-stage destination register.
REQ-010 id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
REQ-011 alu_result  in  XLEN  EX-stage ALU output for the instruction now in EX.
REQ-012 mem_rdata  in  XLEN  data-memory read data for the instruction now in MEM.
REQ-013 ex_op1, ex_op2  out  XLEN  forwarded ALU operands, combinational.
REQ-014 ex_valid, ex_wen, ex_is_load  out  1 each  ID/EX register contents.
REQ-015 ex_rd  out  5  ID/EX destination register.
REQ-016 if_hold  out  1  hold PC and IF/ID; equals stall combinationally.
REQ-017 wb_wen  out  1, wb_rd  out  5, wb_data  out  XLEN  register-file write port.
REQ-018 stall_cnt  out  16  saturating count of stall cycles.
REQ-019 stall_err  out  1  sticky: stall run exceeded STALL_MAX.

Function
REQ-020 ID/EX stage SHALL capture id_valid/id_wen/id_is_load/id_rd/rs1/rs2 data and all four forwarding flags each edge when stall=0.
REQ-021 When stall=1, ID/EX SHALL load a bubble: valid=0, wen=0, is_load=0, rd=0, flags=0, data=0.
REQ-022 EX/MEM stage SHALL capture ex_valid, ex_wen, ex_rd, ex_is_load and alu_result every edge, independent of stall.
REQ-023 MEM/WB stage SHALL capture mem valid/wen/rd every edge and wb_data = mem_is_load ? mem_rdata : mem ALU result.
REQ-024 wb_wen SHALL equal MEM/WB valid AND wen AND (rd != 0).
REQ-025 ex_op1 SHALL be: registered fwd_ex_ex1 ? EX/MEM ALU result : registered fwd_mem_ex1 ? wb_data : ID/EX rs1 data; ex_op2 likewise with the *_ex2 flags.
REQ-026 If both EX and MEM flags are set for one operand, EX_EX SHALL win (newer result).
REQ-027 A forwarding flag set while the source stage is invalid SHALL still select that source (no masking; detector is authoritative).
REQ-028 A flag applied to a bubble SHALL be impossible by REQ-021 (flags cleared).
REQ-029 Latency: an instruction presented in ID with stall=0 SHALL appear on ex_* one cycle later, reach wb_* three cycles later.
REQ-030 stall_cnt SHALL increment by 1 on each edge with stall=1 and saturate at 16'hFFFF.
REQ-031 An internal run counter SHALL count consecutive stall=1 edges and clear on stall=0; when it would exceed STALL_MAX, stall_err SHALL set and remain set until reset.
REQ-032 Simultaneous stall=1 and forwarding flags high: flags SHALL be discarded (bubble), not held.

Reset
REQ-033 On rising edge with rst=0, all pipeline registers SHALL clear to zero (valid=0, wen=0, rd=0, data=0, flags=0).
REQ-034 During and after reset: stall_cnt=0, run counter=0, stall_err=0; ex_op1/ex_op2=0 absent forwarding; wb_wen=0.
REQ-035 Reset asserted mid-stall SHALL abort the stall run; the next stall after reset starts the run count from 0.

Verification
REQ-036 No hazard: rs1=5, rs2=7, flags 0 -> next cycle ex_op1=5, ex_op2=7; wb_data equals that alu_result 2 cycles later.
REQ-037 EX_EX: prior alu_result=0x10, current fwd_ex_ex1=1, rs1=3 -> ex_op1=0x10 while instruction is in EX.
REQ-038 Load-use: load with mem_rdata=0xAB, stall=1 one cycle, then fwd_mem_ex2=1 -> bubble in EX (ex_valid=0), then ex_op2=0xAB; stall_cnt=1, stall_err=0.
REQ-039 Both fwd_ex_ex1 and fwd_mem_ex1 set, EX/MEM ALU=0x1, wb_data=0x2 -> ex_op1=0x1.
REQ-040 stall held 2 consecutive cycles with STALL_MAX=1 -> stall_err=1 and stays 1 after stall drops; rst=0 clears it.
REQ-041 Writeback to rd=0 with wen=1 -> wb_wen=0.
